if_id: RTL

IF_ID -- requirements
Module: IF_ID

---
 rtl/if_id_pkg.sv | 15 +
 rtl/Stall_Watchdog.sv | 34 +++
 rtl/if_id.sv | 94 +++++++++
 3 files changed

// File: rtl/if_id_pkg.sv
// if_id_pkg: shared pipeline constants (NOP, FSM encoding) and the IF/ID next-state helper.
package if_id_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Only consulted on cycles with start asserted; flush always wins over stall.
    function automatic logic [1:0] next_state(input logic [1:0] s, input logic stall, input logic flush);
        return (s == S_IDLE) ? S_RUN : (stall && !flush) ? S_HOLD : S_RUN;
    endfunction

endpackage

// File: rtl/Stall_Watchdog.sv
// Stall_Watchdog: saturating consecutive-stall counter with a sticky timeout once it passes MAX_STALL.
module Stall_Watchdog #(
    parameter int MAX_STALL = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic hold_i,
    output logic timeout_o
);

    localparam int W = $clog2(MAX_STALL + 1) + 1;

    logic [W-1:0] cnt_q, cnt_d;
    logic         tmo_q, tmo_d;

    always_comb begin
        cnt_d = !en_i ? cnt_q : !hold_i ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        tmo_d = tmo_q | (int'(cnt_d) > MAX_STALL);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;

endmodule

// File: rtl/if_id.sv
// if_id: IF/ID pipeline register with stall/flush handling and stall watchdog.
// Optional performance counters enabled by defining IF_ID_PERF_EN.
module if_id
    import if_id_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            Stall_i,
    input  logic            Flush_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o,
    output logic            stall_timeout_o
`ifdef IF_ID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
`endif
);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, instr_q, instr_d;
    logic            valid_q, valid_d;
    logic            active, hold_c, flush_c, keep_c;

    // IDLE ignores stall/flush, so both qualifiers require a started pipeline.
    assign active  = state_q != S_IDLE;
    assign hold_c  = start_i && active && Stall_i && !Flush_i;
    assign flush_c = start_i && active && Flush_i;
    assign keep_c  = !start_i || hold_c;

    always_comb begin
        state_d = start_i ? next_state(state_q, Stall_i, Flush_i) : state_q;
        pc_d    = keep_c ? pc_q : pc_i;
        instr_d = keep_c ? instr_q : flush_c ? XLEN'(NOP) : instr_i;
        valid_d = keep_c ? valid_q : !flush_c;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= XLEN'(NOP);
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    Stall_Watchdog #(.MAX_STALL(MAX_STALL)) u_wd (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (start_i),
        .hold_i   (hold_c),
        .timeout_o(stall_timeout_o)
    );

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;

`ifdef IF_ID_PERF_EN
    logic [CNT_W-1:0] scnt_q, scnt_d, fcnt_q, fcnt_d;

    always_comb begin
        scnt_d = hold_c ? scnt_q + 1'b1 : scnt_q;
        fcnt_d = flush_c ? fcnt_q + 1'b1 : fcnt_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scnt_q <= '0;
            fcnt_q <= '0;
        end else begin
            scnt_q <= scnt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign stall_cnt_o = scnt_q;
    assign flush_cnt_o = fcnt_q;
`endif

endmodule
